// File: rtl/xgmac_loopback_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : xgmac_loopback_fifo
//  Purpose  : Store-and-forward loopback between the 10G MAC rx and tx
//             AXI-Stream interfaces. It can swap the DA and SA of each frame,
//             and it buffers whole frames before exposing them to tx. Frames
//             flagged bad by the MAC, or frames that do not fit, are
//             discarded.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    rx_clk, rx_axis_aresetn : clock and async active-low reset
//    swap_en                 : swap DA/SA, sampled on the first beat of a frame
//    rx_axis_*               : receive stream from the MAC (tready is output)
//    tx_axis_*               : transmit stream to the MAC (tready is input)
//    frames_fwd_cnt          : committed frame count (wraps)
//    frames_drop_cnt         : discarded frame count (wraps)
//    overflow                : one-cycle pulse when a frame is dropped for space
//  Configuration
//    C_DEPTH_LOG2            : FIFO depth of 2^C_DEPTH_LOG2 beats (4..12)
//    XGMAC_LOOPBACK_STATS_EN : when defined, the counters and the overflow
//                              pulse are built. When undefined, those three
//                              outputs are tied to 0.
// ============================================================================
module xgmac_loopback_fifo #(
  parameter int C_DEPTH_LOG2 = 9
) (
  input  logic        rx_clk,
  input  logic        rx_axis_aresetn,
  input  logic        swap_en,
  input  logic [63:0] rx_axis_tdata,
  input  logic [7:0]  rx_axis_tkeep,
  input  logic        rx_axis_tlast,
  input  logic        rx_axis_tuser,
  input  logic        rx_axis_tvalid,
  output logic        rx_axis_tready,
  output logic [63:0] tx_axis_tdata,
  output logic [7:0]  tx_axis_tkeep,
  output logic        tx_axis_tlast,
  output logic        tx_axis_tvalid,
  input  logic        tx_axis_tready,
  output logic [31:0] frames_fwd_cnt,
  output logic [31:0] frames_drop_cnt,
  output logic        overflow
);

  localparam int DEPTH = 1 << C_DEPTH_LOG2;
  localparam int PW    = C_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT1 = 2'd1,
    S_BODY  = 2'd2,
    S_FLUSH = 2'd3
  } wr_state_e;

  wr_state_e     state_q;
  logic [63:0]   hold_data_q;
  logic [7:0]    hold_keep_q;
  logic          swap_q;
  logic          bad_q;
  logic          ovf_q;
  logic          rdy_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] cmt_ptr_q;
  logic [PW-1:0] cmt_vis_q;
  logic [PW-1:0] rd_ptr_q;
  logic          tx_valid_q;
  logic [72:0]   tx_word_q;

  // Each FIFO word is {tlast, tkeep, tdata}.
  logic [72:0]   mem [DEPTH];

  logic          w_acc;
  logic          w_wr_req;
  logic          w_wr_en;
  logic          w_full;
  logic          w_ovf_now;
  logic          w_commit;
  logic          w_pop;
  logic [PW-1:0] w_occ;
  logic [72:0]   w_wr_word;
  logic [63:0]   w_out0;
  logic [63:0]   w_out1;

  assign w_acc = rx_axis_tvalid && rdy_q;

  // Swap mapping across the first two beats (in0 = held, in1 = incoming).
  // out0 = {in0 B1..B0, in1 B3..B0, in0 B7..B6}; out1 = {in1 B7..B4, in0 B5..B2}.
  assign w_out0 = {hold_data_q[15:0], rx_axis_tdata[31:0], hold_data_q[63:48]};
  assign w_out1 = {rx_axis_tdata[63:32], hold_data_q[47:16]};

  always_comb begin
    w_wr_req  = 1'b0;
    w_wr_word = '0;
    case (state_q)
      S_BEAT1: begin
        w_wr_req  = w_acc;
        w_wr_word = {1'b0, hold_keep_q, (swap_q ? w_out0 : hold_data_q)};
      end
      S_BODY: begin
        w_wr_req  = w_acc;
        w_wr_word = {1'b0, hold_keep_q, hold_data_q};
      end
      S_FLUSH: begin
        w_wr_req  = 1'b1;
        w_wr_word = {1'b1, hold_keep_q, hold_data_q};
      end
      default: begin
        w_wr_req  = 1'b0;
        w_wr_word = '0;
      end
    endcase
  end

  // Occupancy counts uncommitted beats too, so a long frame cannot overrun
  // data that tx has not yet consumed.
  assign w_occ     = wr_ptr_q - rd_ptr_q;
  assign w_full    = (w_occ == PW'(DEPTH));
  assign w_wr_en   = w_wr_req && !w_full && !ovf_q;
  assign w_ovf_now = ovf_q || (w_wr_req && w_full);
  assign w_commit  = !bad_q && !w_ovf_now;

  // Write-side FSM. tready is registered and drops only for the FLUSH cycle.
  always_ff @(posedge rx_clk or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      state_q     <= S_IDLE;
      hold_data_q <= '0;
      hold_keep_q <= '0;
      swap_q      <= 1'b0;
      bad_q       <= 1'b0;
      ovf_q       <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (w_acc) begin
            hold_data_q <= rx_axis_tdata;
            hold_keep_q <= rx_axis_tkeep;
            swap_q      <= swap_en;
            ovf_q       <= 1'b0;
            if (rx_axis_tlast) begin
              bad_q   <= rx_axis_tuser;
              rdy_q   <= 1'b0;
              state_q <= S_FLUSH;
            end else begin
              state_q <= S_BEAT1;
            end
          end
        end
        S_BEAT1, S_BODY: begin
          if (w_acc) begin
            hold_data_q <= (state_q == S_BEAT1 && swap_q) ? w_out1 : rx_axis_tdata;
            hold_keep_q <= rx_axis_tkeep;
            if (rx_axis_tlast) begin
              bad_q   <= rx_axis_tuser;
              rdy_q   <= 1'b0;
              state_q <= S_FLUSH;
            end else begin
              state_q <= S_BODY;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
      // Once a write is refused, the rest of the frame is discarded.
      if (w_wr_req && !w_wr_en) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge rx_clk) begin
    if (w_wr_en) begin
      mem[wr_ptr_q[C_DEPTH_LOG2-1:0]] <= w_wr_word;
    end
  end

  // Pointers. A dropped frame rewinds to the last commit point. The commit
  // pointer is re-registered (cmt_vis_q) before the read side can see it.
  always_ff @(posedge rx_clk or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      cmt_vis_q <= '0;
    end else begin
      cmt_vis_q <= cmt_ptr_q;
      if (state_q == S_FLUSH) begin
        if (w_commit) begin
          wr_ptr_q  <= wr_ptr_q + PW'(1);
          cmt_ptr_q <= wr_ptr_q + PW'(1);
        end else begin
          wr_ptr_q  <= cmt_ptr_q;
        end
      end else if (w_wr_en) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
    end
  end

  // Registered tx output stage. It refills whenever it is empty or being
  // drained, so committed frames stream at one beat per cycle.
  assign w_pop = (rd_ptr_q != cmt_vis_q) && (!tx_valid_q || tx_axis_tready);

  always_ff @(posedge rx_clk or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      rd_ptr_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_word_q  <= '0;
    end else if (w_pop) begin
      rd_ptr_q   <= rd_ptr_q + PW'(1);
      tx_valid_q <= 1'b1;
      tx_word_q  <= mem[rd_ptr_q[C_DEPTH_LOG2-1:0]];
    end else if (tx_axis_tready) begin
      tx_valid_q <= 1'b0;
    end
  end

  assign rx_axis_tready = rdy_q;
  assign tx_axis_tvalid = tx_valid_q;
  assign tx_axis_tlast  = tx_word_q[72];
  assign tx_axis_tkeep  = tx_word_q[71:64];
  assign tx_axis_tdata  = tx_word_q[63:0];

`ifdef XGMAC_LOOPBACK_STATS_EN
  logic [31:0] fwd_cnt_q;
  logic [31:0] drop_cnt_q;
  logic        ovf_pulse_q;

  always_ff @(posedge rx_clk or negedge rx_axis_aresetn) begin
    if (!rx_axis_aresetn) begin
      fwd_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      ovf_pulse_q <= 1'b0;
    end else begin
      ovf_pulse_q <= 1'b0;
      if (state_q == S_FLUSH) begin
        if (w_commit) begin
          fwd_cnt_q <= fwd_cnt_q + 32'd1;
        end else begin
          drop_cnt_q  <= drop_cnt_q + 32'd1;
          ovf_pulse_q <= w_ovf_now;
        end
      end
    end
  end

  assign frames_fwd_cnt  = fwd_cnt_q;
  assign frames_drop_cnt = drop_cnt_q;
  assign overflow        = ovf_pulse_q;
`else
  assign frames_fwd_cnt  = '0;
  assign frames_drop_cnt = '0;
  assign overflow        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xgmac_loopback_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xgmac_loopback_fifo
//  Purpose  : Directed self-checking bench for xgmac_loopback_fifo
//             (C_DEPTH_LOG2 = 4). A frame-level byte model predicts the tx
//             stream and the statistics.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_xgmac_loopback_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        swap_en = 1'b0;
  logic [63:0] rx_tdata = '0;
  logic [7:0]  rx_tkeep = '0;
  logic        rx_tlast = 1'b0;
  logic        rx_tuser = 1'b0;
  logic        rx_tvalid = 1'b0;
  logic        rx_tready;
  logic [63:0] tx_tdata;
  logic [7:0]  tx_tkeep;
  logic        tx_tlast;
  logic        tx_tvalid;
  logic        tx_tready = 1'b1;
  logic [31:0] fwd_cnt;
  logic [31:0] drop_cnt;
  logic        ovf;

  always #5 clk = ~clk;

  xgmac_loopback_fifo #(.C_DEPTH_LOG2(4)) dut (
    .rx_clk          (clk),
    .rx_axis_aresetn (rst_n),
    .swap_en         (swap_en),
    .rx_axis_tdata   (rx_tdata),
    .rx_axis_tkeep   (rx_tkeep),
    .rx_axis_tlast   (rx_tlast),
    .rx_axis_tuser   (rx_tuser),
    .rx_axis_tvalid  (rx_tvalid),
    .rx_axis_tready  (rx_tready),
    .tx_axis_tdata   (tx_tdata),
    .tx_axis_tkeep   (tx_tkeep),
    .tx_axis_tlast   (tx_tlast),
    .tx_axis_tvalid  (tx_tvalid),
    .tx_axis_tready  (tx_tready),
    .frames_fwd_cnt  (fwd_cnt),
    .frames_drop_cnt (drop_cnt),
    .overflow        (ovf)
  );

`ifdef XGMAC_LOOPBACK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  int fwd_exp = 0;
  int drop_exp = 0;
  int ovf_seen = 0;

  logic [72:0] exp_q [$];     // expected tx beats {tlast, tkeep, tdata}
  logic [63:0] obs_data [$];  // every tx beat observed
  logic [7:0]  fb [0:255];    // frame bytes for the next send_frame

  logic        prev_stall = 1'b0;
  logic [72:0] prev_word = '0;

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Compare process: every accepted tx beat against the model queue,
  // and tx stability while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ovf) ovf_seen++;
      if (prev_stall) check("tx hold stable", {tx_tlast, tx_tkeep, tx_tdata}, prev_word);
      if (tx_tvalid && tx_tready) begin
        obs_data.push_back(tx_tdata);
        if (exp_q.size() == 0) begin
          check("unexpected tx beat", 73'(tx_tvalid), 73'(0));
        end else begin
          check("tx beat", {tx_tlast, tx_tkeep, tx_tdata}, exp_q.pop_front());
        end
      end
      prev_stall = tx_tvalid && !tx_tready;
      prev_word  = {tx_tlast, tx_tkeep, tx_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Predicts the frame at byte level, then drives it beat by beat.
  // abort_at > 0 stops after that many beats without tlast.
  task automatic send_frame(input int len, input bit swp, input bit bad,
                            input bit ovf_drop, input int abort_at);
    int          nb;
    int          g;
    logic [7:0]  e [0:255];
    logic [7:0]  t;
    logic [63:0] d;
    logic [7:0]  k;
    nb = (len + 7) / 8;
    if (abort_at == 0) begin
      for (int i = 0; i < 256; i++) e[i] = (i < len) ? fb[i] : 8'h00;
      if (swp && nb > 1) begin
        for (int i = 0; i < 6; i++) begin
          t = e[i]; e[i] = e[i+6]; e[i+6] = t;
        end
      end
      if (bad || ovf_drop) begin
        drop_exp++;
      end else begin
        fwd_exp++;
        for (int bt = 0; bt < nb; bt++) begin
          for (int j = 0; j < 8; j++) begin
            d[8*j +: 8] = e[bt*8 + j];
            k[j]        = (bt*8 + j < len);
          end
          exp_q.push_back({(bt == nb - 1), k, d});
        end
      end
    end
    for (int bt = 0; bt < nb; bt++) begin
      if (abort_at != 0 && bt == abort_at) return;
      for (int j = 0; j < 8; j++) begin
        d[8*j +: 8] = (bt*8 + j < len) ? fb[bt*8 + j] : 8'h00;
        k[j]        = (bt*8 + j < len);
      end
      @(negedge clk);
      rx_tdata  = d;
      rx_tkeep  = k;
      rx_tlast  = (bt == nb - 1);
      rx_tuser  = (bt == nb - 1) && bad;
      rx_tvalid = 1'b1;
      swap_en   = swp;
      g = 0;
      while (!rx_tready && g < 20) begin
        @(negedge clk);
        g++;
      end
      if (g >= 20) check("rx_tready wait", 73'(rx_tready), 73'(1));
      @(posedge clk);
    end
    @(negedge clk);
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
    rx_tuser  = 1'b0;
  endtask

  task automatic drain(input string name);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    repeat (4) @(negedge clk);
    check({name, " drained"}, 73'(exp_q.size()), 73'(0));
    check({name, " tvalid idle"}, 73'(tx_tvalid), 73'(0));
  endtask

  task automatic check_counters(input string name);
    check({name, " fwd_cnt"}, 73'(fwd_cnt), STATS ? 73'(fwd_exp) : 73'(0));
    check({name, " drop_cnt"}, 73'(drop_cnt), STATS ? 73'(drop_exp) : 73'(0));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " rx_tready"}, 73'(rx_tready), 73'(0));
    check({name, " tx word"}, {tx_tlast, tx_tkeep, tx_tdata}, 73'(0));
    check({name, " tx_tvalid"}, 73'(tx_tvalid), 73'(0));
    check({name, " stats"}, {8'(0), fwd_cnt, drop_cnt, ovf}, 73'(0));
  endtask

  task automatic fill_std_frame();
    logic [47:0] da;
    logic [47:0] sa;
    da = 48'h001122334455;
    sa = 48'h66778899AABB;
    for (int i = 0; i < 256; i++) fb[i] = 8'(i);
    for (int i = 0; i < 6; i++) begin
      fb[i]   = da[8*(5-i) +: 8];
      fb[i+6] = sa[8*(5-i) +: 8];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("tready after reset", 73'(rx_tready), 73'(1));

    // Swap: DA/SA exchanged, payload intact
    fill_std_frame();
    base = obs_data.size();
    send_frame(64, 1'b1, 1'b0, 1'b0, 0);
    drain("swap");
    check("swap beat0 literal", 73'(obs_data[base]), 73'(64'h1100BBAA99887766));
    check("swap beat1 literal", 73'(obs_data[base+1]), 73'(64'h0F0E0D0C55443322));
    check("swap beat7 literal", 73'(obs_data[base+7]), 73'(64'h3F3E3D3C3B3A3938));
    check_counters("swap");

    // Passthrough
    base = obs_data.size();
    send_frame(64, 1'b0, 1'b0, 1'b0, 0);
    drain("pass");
    check("pass beat0 literal", 73'(obs_data[base]), 73'(64'h7766554433221100));

    // Bad frame A then good frame B
    send_frame(40, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 256; i++) fb[i] = 8'(8'h80 + i);
    send_frame(24, 1'b1, 1'b0, 1'b0, 0);
    drain("bad");
    check_counters("bad");
    check("bad no overflow", 73'(ovf_seen), 73'(0));

    // Overflow: tx stalled, 8-beat frame fits, 20-beat frame cannot
    tx_tready = 1'b0;
    fill_std_frame();
    send_frame(64, 1'b0, 1'b0, 1'b0, 0);
    send_frame(160, 1'b0, 1'b0, 1'b1, 0);
    repeat (5) @(negedge clk);
    check("overflow pulses", 73'(ovf_seen), STATS ? 73'(1) : 73'(0));
    check_counters("overflow");
    tx_tready = 1'b1;
    drain("overflow");

    // Short frames: single beat never swapped; 2-beat frame swapped
    for (int i = 0; i < 256; i++) fb[i] = 8'(8'hA0 + i);
    base = obs_data.size();
    send_frame(4, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 256; i++) fb[i] = 8'(8'hC0 + i);
    send_frame(12, 1'b1, 1'b0, 1'b0, 0);
    drain("short");
    check("short 1-beat literal", 73'(obs_data[base]), 73'(64'h00000000A3A2A1A0));
    check("short 2-beat b0", 73'(obs_data[base+1]), 73'(64'hC1C0CBCAC9C8C7C6));
    check("short 2-beat b1", 73'(obs_data[base+2]), 73'(64'h00000000C5C4C3C2));
    check_counters("short");

    // Reset asserted mid-frame
    fill_std_frame();
    send_frame(64, 1'b0, 1'b0, 1'b0, 3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid-frame reset");
    rx_tvalid = 1'b0;
    rx_tlast  = 1'b0;
    exp_q.delete();
    fwd_exp  = 0;
    drop_exp = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    base = obs_data.size();
    send_frame(64, 1'b1, 1'b0, 1'b0, 0);
    drain("post-reset");
    check("post-reset beat0", 73'(obs_data[base]), 73'(64'h1100BBAA99887766));
    check_counters("post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
